// File: rtl/mat_pkg.sv
// Shared types and index helpers for the streaming matrix blocks
// (mattrans_stream and the mat_serialise/mat_deserialise family).
package mat_pkg;

  localparam int MAX_N     = 16;
  localparam int MAX_IDX_W = $clog2(MAX_N * MAX_N);
  localparam int RC_W      = $clog2(MAX_N);

  typedef logic bank_t;

  typedef struct packed {
    logic [RC_W-1:0] row;
    logic [RC_W-1:0] col;
  } rc_t;

  // Width of a linear element index for an n x n matrix.
  function automatic int idx_w(input int n);
    return $clog2(n * n);
  endfunction

  // Row-major linear index to (row, col).
  function automatic rc_t idx_to_rc(input logic [MAX_IDX_W-1:0] idx, input int n);
    rc_t rc;
    rc.row = RC_W'(int'(idx) / n);
    rc.col = RC_W'(int'(idx) % n);
    return rc;
  endfunction

endpackage

// File: rtl/mattrans_stream_if.sv
// Element-stream bus of the streaming transposer: input stream, output stream
// and the sticky framing status. The block itself sits on the slave modport.
interface mattrans_stream_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  frame_err;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, frame_err
  );

endinterface

// File: rtl/mat_bank.sv
// One matrix bank: DEPTH-entry register file, one synchronous write port and
// one asynchronous read port.
module mat_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; the parent's full flags define which contents
  // are meaningful, so clearing the storage would only add a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mattrans_stream.sv
// Streaming N x N transposer: row-major elements in, column-major out,
// ping-pong banks for 1 element/cycle sustained throughput.
module mattrans_stream
  import mat_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BIN_POS     = 16,
  parameter int MATRIX_SIZE = 4
) (
  input logic              clk,
  input logic              rst_n,
  mattrans_stream_if.slave s
);

  localparam int                IDX_W    = idx_w(MATRIX_SIZE);
  localparam int                DEPTH    = MATRIX_SIZE * MATRIX_SIZE;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  // BIN_POS is carried for interface uniformity only; the data path never scales.
  if (MATRIX_SIZE < 2 || MATRIX_SIZE > MAX_N || BIN_POS < 0) begin : g_bad_param
    $error("mattrans_stream: illegal parameter set");
  end

  logic [IDX_W-1:0]      r_wr_idx, r_rd_idx;
  bank_t                 r_wr_bank, r_rd_bank;
  logic [1:0]            r_full;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid, r_out_last, r_frame_err;

  logic                  w_in_fire, w_wr_done, w_load, w_rd_done;
  logic [1:0]            w_we;
  rc_t                   w_rd_rc;
  logic [IDX_W-1:0]      w_rd_addr;
  logic [DATA_WIDTH-1:0] w_rdata [2];

  // NOTE: every signal gets a default before any conditional assignment so no
  // path through this block can leave a value held, which would infer a latch.
  always_comb begin
    w_we              = '0;
    w_in_fire         = s.in_valid && !r_full[r_wr_bank];
    w_wr_done         = w_in_fire && (r_wr_idx == LAST_IDX);
    w_we[r_wr_bank]   = w_in_fire;
    w_load            = r_full[r_rd_bank] && (!r_out_valid || s.out_ready);
    w_rd_done         = w_load && (r_rd_idx == LAST_IDX);
    // Output element rd_idx lives at row = rd_idx % N, col = rd_idx / N.
    w_rd_rc           = idx_to_rc(MAX_IDX_W'(r_rd_idx), MATRIX_SIZE);
    w_rd_addr         = IDX_W'(int'(w_rd_rc.col) * MATRIX_SIZE + int'(w_rd_rc.row));
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    mat_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (IDX_W)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_we[b]),
      .i_waddr (r_wr_idx),
      .i_wdata (s.in_data),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rdata[b])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the processes are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx    <= '0;
      r_wr_bank   <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (w_in_fire) begin
      if (s.in_last != (r_wr_idx == LAST_IDX)) r_frame_err <= 1'b1;
      if (w_wr_done) begin
        r_wr_idx  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else begin
        r_wr_idx  <= r_wr_idx + IDX_W'(1);
      end
    end
  end

  // A bank is only written while empty and only drained while full, so the
  // set and clear of one flag can never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_wr_done && r_wr_bank == bank_t'(b))      r_full[b] <= 1'b1;
        else if (w_rd_done && r_rd_bank == bank_t'(b)) r_full[b] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_idx    <= '0;
      r_rd_bank   <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_rdata[r_rd_bank];
      r_out_valid <= 1'b1;
      r_out_last  <= w_rd_done;
      if (w_rd_done) begin
        r_rd_idx  <= '0;
        r_rd_bank <= ~r_rd_bank;
      end else begin
        r_rd_idx  <= r_rd_idx + IDX_W'(1);
      end
    end else if (s.out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // in_ready comes from flops only: it never sees in_valid, and a bank release
  // reaches it one cycle after the final read.
  assign s.in_ready  = !r_full[r_wr_bank];
  assign s.out_data  = r_out_data;
  assign s.out_valid = r_out_valid;
  assign s.out_last  = r_out_last;
  assign s.frame_err = r_frame_err;

endmodule

// File: tb/tb_mattrans_stream.sv
// Self-checking bench for mattrans_stream: directed 3x3 sequences on an 8-bit
// instance and a long randomly throttled 4x4 run on a 32-bit instance.
module tb_mattrans_stream;

  localparam int DW3  = 8;
  localparam int N3   = 3;
  localparam int DW4  = 32;
  localparam int N4   = 4;
  localparam int BP   = 16;
  localparam int NMAT = 1000;
  localparam int NEL4 = NMAT * N4 * N4;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mattrans_stream_if #(.DATA_WIDTH(DW3)) if3 ();
  mattrans_stream_if #(.DATA_WIDTH(DW4)) if4 ();

  mattrans_stream #(.DATA_WIDTH(DW3), .BIN_POS(4), .MATRIX_SIZE(N3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (if3.slave)
  );

  mattrans_stream #(.DATA_WIDTH(DW4), .BIN_POS(BP), .MATRIX_SIZE(N4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (if4.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    logic       din_last;
    logic [7:0] dout;
    logic       dout_last;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] rnd_mem [NEL4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected k-th output of a 3x3 matrix whose row-major element p is base+p+1.
  function automatic logic [7:0] tval(input logic [7:0] base, input int k);
    return base + 8'((k % 3) * 3 + k / 3 + 1);
  endfunction

  task automatic push_mat(input logic [7:0] base);
    for (int k = 0; k < 9; k++) exp_q.push_back('{tval(base, k), (k == 8)});
  endtask

  // Present one element and hold it until accepted; counts wait cycles.
  task automatic send3(input logic [7:0] d, input logic l, inout int stalls);
    bit done;
    done = 1'b0;
    if3.in_data  = d;
    if3.in_last  = l;
    if3.in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = if3.in_ready;
      if (!done) stalls++;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_mat3(input logic [7:0] base, inout int stalls);
    for (int p = 0; p < 9; p++) send3(8'(base + 8'(p + 1)), (p == 8), stalls);
  endtask

  // Take count transfers from the output, comparing against exp_q.
  task automatic collect3(input string name, input int count);
    int   got;
    exp_t e;
    got = 0;
    for (int t = 0; t < 400 && got < count; t++) begin
      @(negedge clk);
      if (if3.out_valid && if3.out_ready) begin
        if (exp_q.size() == 0) begin
          check({name, "_unexpected"}, 32'(if3.out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check({name, "_data"}, 32'(if3.out_data), 32'(e.d));
          check({name, "_last"}, 32'(if3.out_last), 32'(e.l));
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    if (got < count) check({name, "_timeout"}, 32'(got), 32'(count));
  endtask

  task automatic run_basic();
    vec_t vecs[9];
    int   st;
    vecs[0] = '{8'h01, 1'b0, 8'h01, 1'b0};
    vecs[1] = '{8'h02, 1'b0, 8'h04, 1'b0};
    vecs[2] = '{8'h03, 1'b0, 8'h07, 1'b0};
    vecs[3] = '{8'h04, 1'b0, 8'h02, 1'b0};
    vecs[4] = '{8'h05, 1'b0, 8'h05, 1'b0};
    vecs[5] = '{8'h06, 1'b0, 8'h08, 1'b0};
    vecs[6] = '{8'h07, 1'b0, 8'h03, 1'b0};
    vecs[7] = '{8'h08, 1'b0, 8'h06, 1'b0};
    vecs[8] = '{8'h09, 1'b1, 8'h09, 1'b1};
    st = 0;
    if3.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send3(vecs[i].din, vecs[i].din_last, st);
    if3.in_valid = 1'b0;
    check("basic_in_ready", 32'(st), 32'd0);
    @(negedge clk);
    check("basic_latency_early", 32'(if3.out_valid), 32'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("basic_valid", 32'(if3.out_valid), 32'd1);
      check("basic_data",  32'(if3.out_data),  32'(vecs[i].dout));
      check("basic_last",  32'(if3.out_last),  32'(vecs[i].dout_last));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_two();
    if3.out_ready = 1'b1;
    fork
      begin
        int st;
        st = 0;
        send_mat3(8'h00, st);
        send_mat3(8'h10, st);
        if3.in_valid = 1'b0;
        check("two_in_ready", 32'(st), 32'd0);
      end
      begin
        bit found;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
          @(negedge clk);
          found = if3.out_valid;
        end
        if (!found) begin
          check("two_start_timeout", 32'd0, 32'd1);
        end else begin
          for (int k = 0; k < 18; k++) begin
            if (k > 0) @(negedge clk);
            check("two_valid", 32'(if3.out_valid), 32'd1);
            check("two_data",  32'(if3.out_data),  32'(tval((k < 9) ? 8'h00 : 8'h10, k % 9)));
            check("two_last",  32'(if3.out_last),  32'((k % 9) == 8));
          end
        end
      end
    join
    @(posedge clk);
    #1;
  endtask

  task automatic run_backpressure();
    int st;
    st = 0;
    if3.out_ready = 1'b0;
    send_mat3(8'h00, st);
    send_mat3(8'h10, st);
    check("bp_first18_stalls", 32'(st), 32'd0);
    if3.in_data = 8'h21;
    if3.in_last = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(if3.in_ready),  32'd0);
      check("bp_hold_valid",   32'(if3.out_valid), 32'd1);
      check("bp_hold_data",    32'(if3.out_data),  32'h01);
      @(posedge clk);
      #1;
    end
    push_mat(8'h00);
    push_mat(8'h10);
    push_mat(8'h20);
    fork
      begin
        int st2;
        st2 = 0;
        send_mat3(8'h20, st2);
        if3.in_valid = 1'b0;
      end
      begin
        if3.out_ready = 1'b1;
        collect3("bp", 27);
      end
    join
  endtask

  task automatic run_frame();
    int st;
    st = 0;
    if3.out_ready = 1'b1;
    check("frame_pre", 32'(if3.frame_err), 32'd0);
    for (int p = 0; p < 9; p++) begin
      send3(8'(8'h31 + 8'(p)), (p == 4) || (p == 8), st);
      if (p == 3) check("frame_before", 32'(if3.frame_err), 32'd0);
      if (p == 4) check("frame_set",    32'(if3.frame_err), 32'd1);
    end
    if3.in_valid = 1'b0;
    push_mat(8'h30);
    collect3("frame", 9);
    check("frame_sticky", 32'(if3.frame_err), 32'd1);
  endtask

  task automatic run_reset_mid();
    int st;
    st = 0;
    if3.out_ready = 1'b0;
    send_mat3(8'h40, st);
    for (int p = 0; p < 4; p++) send3(8'(8'h51 + 8'(p)), 1'b0, st);
    if3.in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", 32'(if3.out_valid), 32'd1);
    check("rst_pre_data",  32'(if3.out_data),  32'h41);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(if3.out_valid), 32'd0);
    check("rst_async_data",  32'(if3.out_data),  32'd0);
    check("rst_async_last",  32'(if3.out_last),  32'd0);
    check("rst_async_ferr",  32'(if3.frame_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready",   32'(if3.in_ready),  32'd1);
    check("rst_post_valid", 32'(if3.out_valid), 32'd0);
    if3.out_ready = 1'b1;
    st = 0;
    send_mat3(8'h60, st);
    if3.in_valid = 1'b0;
    check("rst_fresh_stalls", 32'(st), 32'd0);
    push_mat(8'h60);
    collect3("rst_fresh", 9);
  endtask

  task automatic run_random();
    for (int i = 0; i < NEL4; i++) begin
      int v;
      v = $random % 10;
      rnd_mem[i] = 32'(v <<< BP);
    end
    fork
      begin
        bit done;
        for (int i = 0; i < NEL4; i++) begin
          while ($urandom_range(0, 3) == 0) begin
            if4.in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          if4.in_data  = rnd_mem[i];
          if4.in_last  = ((i % 16) == 15);
          if4.in_valid = 1'b1;
          done = 1'b0;
          for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            done = if4.in_ready;
            @(posedge clk);
            #1;
          end
          if (!done) begin
            check("rnd_send_timeout", 32'd0, 32'd1);
            break;
          end
        end
        if4.in_valid = 1'b0;
      end
      begin
        int got, m, k, p;
        got = 0;
        for (int t = 0; t < 60000 && got < NEL4; t++) begin
          if4.out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (if4.out_valid) begin
            m = got / 16;
            k = got % 16;
            p = (k % 4) * 4 + k / 4;
            check("rnd_data", if4.out_data, rnd_mem[m * 16 + p]);
            check("rnd_last", 32'(if4.out_last), 32'(k == 15));
            if (if4.out_ready) got++;
          end
          @(posedge clk);
          #1;
        end
        if (got < NEL4) check("rnd_timeout", 32'(got), 32'(NEL4));
        if4.out_ready = 1'b0;
      end
    join
  endtask

  initial begin
    rst_n         = 1'b0;
    if3.in_data   = '0;
    if3.in_valid  = 1'b0;
    if3.in_last   = 1'b0;
    if3.out_ready = 1'b0;
    if4.in_data   = '0;
    if4.in_valid  = 1'b0;
    if4.in_last   = 1'b0;
    if4.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(if3.out_valid), 32'd0);
    check("reset_out_data",  32'(if3.out_data),  32'd0);
    check("reset_out_last",  32'(if3.out_last),  32'd0);
    check("reset_frame_err", 32'(if3.frame_err), 32'd0);
    check("reset_valid_n4",  32'(if4.out_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", 32'(if3.in_ready), 32'd1);

    run_basic();
    run_two();
    run_backpressure();
    run_frame();
    run_reset_mid();
    run_random();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mattrans_stream.md
Name: mattrans_stream

Overview:
- Streaming, sequential counterpart to the combinational transposer. Accepts one fixed-point matrix element per cycle in row-major order and emits the same matrix in column-major order, which is the transposed matrix in row-major order.
- Sits between serial matrix producers and consumers, such as the matmul/navigation datapath, where full flattened matrix buses are too wide.
- Ping-pong double buffering gives a sustained throughput of 1 element/cycle.

Parameters:
- DATA_WIDTH, 32, element width in bits (signed fixed point).
- BIN_POS, 16, binary point position. Pass-through only; no arithmetic depends on it. Kept for interface uniformity with the other mat* blocks.
- MATRIX_SIZE, 4, N for an N×N matrix; legal range 2..16.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_WIDTH  input element.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept in_data this cycle.
- in_last  in  1  marks element N²-1 of a matrix; framing check only.
- out_data  out  DATA_WIDTH  transposed element.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  marks the final element of the output matrix.
- frame_err  out  1  sticky in_last framing error.

Behaviour:
- Reset (async assert on rst_n=0, sync deassert):
  - out_valid=0, out_last=0, out_data=0, frame_err=0.
  - Both banks empty; write and read counters 0; write and read bank pointers 0.
  - in_ready=1 from the first cycle after reset release.
  - Reset mid-frame discards all buffered and partially written data.
- Handshakes are AXI-stream style:
  - Transfer occurs when valid and ready are both 1 on a clock edge.
  - out_valid, once high, stays high with out_data and out_last stable until out_ready.
  - in_ready does not depend combinationally on in_valid.
- Storage: two banks, each holding N² elements, with a full flag per bank.
- Write side:
  - wr_idx runs 0..N²-1 and maps to row=wr_idx/N, col=wr_idx%N.
  - in_ready = !full[wr_bank].
  - On accepting element N²-1: set full[wr_bank], toggle wr_bank, reset wr_idx to 0.
  - Framing is by count only.
- Framing error: frame_err is set when in_last=1 at wr_idx≠N²-1, or in_last=0 at wr_idx=N²-1. It is cleared only by reset and does not alter data flow.
- Read side:
  - rd_idx runs 0..N²-1 and reads element row=rd_idx%N, col=rd_idx/N of bank rd_bank.
  - The output register loads when full[rd_bank] and (!out_valid or out_ready).
  - out_last=1 when the loaded rd_idx=N²-1.
  - When the last element is loaded: clear full[rd_bank], toggle rd_bank, reset rd_idx to 0.
- Latency: the first out_valid occurs in the cycle after the edge that accepts the N²-th input. With no backpressure, output runs 1 element/cycle, back-to-back across matrices.
- Simultaneous events:
  - A write to one bank and a drain of the other in the same cycle are legal.
  - If the last element of a bank is loaded to the output in the same cycle the writer is waiting on that bank, in_ready rises the next cycle. No combinational path from the full-clear to in_ready.
- Both banks full: in_ready=0 until the reader releases a bank.
- Counters wrap at N²; matrix count is unbounded.

Decomposition:
- Package mat_pkg holds:
  - IDX_W = $clog2(MATRIX_SIZE*MATRIX_SIZE);
  - an index→row/col helper function;
  - a 1-bit bank_t typedef.
- Shared with the future mat_deserialise/mat_serialise blocks.
- One natural sub-module: mat_bank, an N²-entry register file with 1 write and 1 async read port, instantiated twice.
- Top-level holds the counters, flags and output register.

Test Plan:
- N=3, DATA_WIDTH=8, in_data 01..09 back-to-back with out_ready=1:
  - outputs 01,04,07,02,05,08,03,06,09;
  - out_last only on 09;
  - first out_valid 1 cycle after 09 is accepted.
- Two matrices streamed continuously (01..09, then 11..19):
  - in_ready stays 1 throughout;
  - outputs 01,04,07,…,09 then 11,14,17,…,19 with no bubble.
- out_ready=0 held for the duration of three matrices:
  - in_ready drops after the 18th accepted element (both banks full);
  - out_data holds 01 stable;
  - releasing out_ready drains all data in correct order.
- Random valid/ready toggling, 1000 matrices of $random%10<<<BIN_POS values with N=4:
  - output equals the software transpose of each input matrix.
- in_last asserted on element 5 of 9:
  - frame_err=1 next cycle and stays 1;
  - output data still correctly transposed.
- rst_n pulsed low after 4 of 9 elements:
  - outputs go to 0 immediately;
  - after release, in_ready=1;
  - a fresh 9-element matrix transposes correctly with no residue.
